// File: rtl/instruction_fetch_stage_pkg.sv
// Shared types and constants for the instruction fetch stage.
package instruction_fetch_stage_pkg;

  typedef enum logic [1:0] {
    StRun    = 2'd0,
    StHalted = 2'd1,
    StFault  = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NopWord          = 32'h0000_0000;
  localparam logic [31:0] DefaultHaltInstr = 32'hFFFF_FFFF;
  localparam logic [31:0] PcIncr           = 32'd4;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] value);
    return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/instruction_fetch_stage_if.sv
// Fetch-stage signal bundle: decode/branch controls, instruction memory bus, IF/ID and status.
interface instruction_fetch_stage_if;

  logic        stall;
  logic        flush;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic [31:0] imem_instr;
  logic [31:0] pc_out;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc_plus4;
  logic        ifid_valid;
  logic        halted;
  logic        fault;
  logic [31:0] fetch_count;

  // The fetch stage itself.
  modport master (
    input  stall, flush, branch_taken, branch_target, jump, jump_target, imem_instr,
    output pc_out, ifid_instr, ifid_pc_plus4, ifid_valid, halted, fault, fetch_count
  );

  // Surrounding pipeline and instruction memory.
  modport slave (
    output stall, flush, branch_taken, branch_target, jump, jump_target, imem_instr,
    input  pc_out, ifid_instr, ifid_pc_plus4, ifid_valid, halted, fault, fetch_count
  );

endinterface

// File: rtl/if_id_register.sv
// IF/ID pipeline register: load a fetched instruction, insert a bubble, or hold.
module if_id_register
  import instruction_fetch_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic        bubble_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_plus4_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_plus4_o,
  output logic        valid_o
);

  logic [31:0] instr_q;
  logic [31:0] pc_plus4_q;
  logic        valid_q;

  // Bubble beats load; neither asserted means hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q    <= NopWord;
      pc_plus4_q <= 32'd0;
      valid_q    <= 1'b0;
    end else if (bubble_i) begin
      instr_q    <= NopWord;
      pc_plus4_q <= 32'd0;
      valid_q    <= 1'b0;
    end else if (load_i) begin
      instr_q    <= instr_i;
      pc_plus4_q <= pc_plus4_i;
      valid_q    <= 1'b1;
    end
  end

  assign instr_o    = instr_q;
  assign pc_plus4_o = pc_plus4_q;
  assign valid_o    = valid_q;

endmodule

// File: rtl/instruction_fetch_stage.sv
// Instruction fetch stage: PC sequencing, redirects, stall/flush, halt and fault detection.
module instruction_fetch_stage
  import instruction_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_DEPTH = 100,
  parameter logic [31:0] HALT_INSTR = DefaultHaltInstr
) (
  input  logic                       clk,
  input  logic                       rst,
  instruction_fetch_stage_if.master  fif
);

  fetch_state_e state_q;
  logic [31:0]  pc_q;
  logic [31:0]  count_q;
  logic         halted_q;
  logic         fault_q;

  logic [31:0] pc_plus4;
  logic [31:0] redirect_pc;
  logic        redirect;
  logic        bad_pc;
  logic        halt_hit;
  logic        do_redirect;
  logic        do_stall;
  logic        do_fault;
  logic        do_halt;
  logic        do_advance;
  logic        ifid_load;
  logic        ifid_bubble;

  // Decode this edge's action in priority order: redirect, stall, fault, halt, advance.
  always_comb begin
    pc_plus4    = pc_q + PcIncr;
    redirect    = fif.branch_taken | fif.jump;
    redirect_pc = fif.branch_taken ? fif.branch_target : fif.jump_target;
    bad_pc      = (pc_q[1:0] != 2'b00) || ((pc_q >> 2) >= 32'(IMEM_DEPTH));
    halt_hit    = (fif.imem_instr == HALT_INSTR);
    do_redirect = (state_q == StRun) && redirect;
    do_stall    = (state_q == StRun) && !redirect && fif.stall;
    do_fault    = (state_q == StRun) && !redirect && !fif.stall && bad_pc;
    do_halt     = (state_q == StRun) && !redirect && !fif.stall && !bad_pc && halt_hit;
    do_advance  = (state_q == StRun) && !redirect && !fif.stall && !bad_pc && !halt_hit;
    ifid_load   = do_advance && !fif.flush;
    // Frozen states keep IF/ID empty; flush only bites when IF/ID would otherwise hold or load.
    ifid_bubble = (state_q != StRun) || do_redirect || do_fault || do_halt ||
                  ((do_stall || do_advance) && fif.flush);
  end

  // Fetch FSM with PC, fetch counter and registered status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StRun;
      pc_q     <= RESET_PC;
      count_q  <= 32'd0;
      halted_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      case (state_q)
        StRun: begin
          if (do_redirect) begin
            pc_q <= redirect_pc;
          end else if (do_fault) begin
            state_q <= StFault;
            fault_q <= 1'b1;
          end else if (do_halt) begin
            state_q  <= StHalted;
            halted_q <= 1'b1;
          end else if (do_advance) begin
            pc_q <= pc_plus4;
            if (!fif.flush) begin
              count_q <= sat_inc(count_q);
            end
          end
        end
        StHalted, StFault: begin
          // Only reset leaves these states.
        end
        default: begin
          state_q <= StRun;
        end
      endcase
    end
  end

  if_id_register u_if_id_register (
    .clk        (clk),
    .rst        (rst),
    .load_i     (ifid_load),
    .bubble_i   (ifid_bubble),
    .instr_i    (fif.imem_instr),
    .pc_plus4_i (pc_plus4),
    .instr_o    (fif.ifid_instr),
    .pc_plus4_o (fif.ifid_pc_plus4),
    .valid_o    (fif.ifid_valid)
  );

  assign fif.pc_out      = pc_q;
  assign fif.fetch_count = count_q;
  assign fif.halted      = halted_q;
  assign fif.fault       = fault_q;

endmodule

// File: doc/instruction_fetch_stage.md
INSTRUCTION_FETCH_STAGE -- requirements
Module: instruction_fetch_stage

Interface
REQ-001 Param RESET_PC, 32'h0000_0000, PC value loaded on reset.
REQ-002 Param IMEM_DEPTH, 100, instruction memory depth in words; word index PC>>2 must be < IMEM_DEPTH.
REQ-003 Param HALT_INSTR, 32'hFFFF_FFFF, instruction word that stops fetching.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 stall  input  1  hold PC and IF/ID contents (load-use hazard from decode).
REQ-007 flush  input  1  force a bubble into IF/ID on the next edge.
REQ-008 branch_taken  input  1  redirect PC to branch_target.
REQ-009 branch_target  input  32  byte address of the branch destination.
REQ-010 jump  input  1  redirect PC to jump_target.
REQ-011 jump_target  input  32  byte address of the jump destination.
REQ-012 imem_instr  input  32  instruction word returned combinationally by instruction memory for pc_out.
REQ-013 pc_out  output  32  current PC; drives the instruction memory address.
REQ-014 ifid_instr  output  32  registered instruction to decode.
REQ-015 ifid_pc_plus4  output  32  registered PC+4 of that instruction.
REQ-016 ifid_valid  output  1  1 = IF/ID holds a real instruction, 0 = bubble.
REQ-017 halted  output  1  HALT_INSTR fetched; fetching stopped.
REQ-018 fault  output  1  PC misaligned or out of range; fetching stopped.
REQ-019 fetch_count  output  32  number of instructions accepted into IF/ID.

Function
REQ-020 State machine SHALL have states RUN, HALTED, FAULT; halted=1 only in HALTED, fault=1 only in FAULT.
REQ-021 Per-edge priority in RUN SHALL be: redirect > stall > halt/fault detect > normal advance.
REQ-022 Redirect: branch_taken=1 loads branch_target; else jump=1 loads jump_target; IF/ID becomes bubble (instr 0, valid 0); applies even if stall=1.
REQ-023 Branch and jump asserted together: branch_target wins.
REQ-024 stall=1 with no redirect: PC, IF/ID, fetch_count unchanged; flush=1 in the same cycle still clears IF/ID to bubble.
REQ-025 Normal advance: PC <= PC+4 (mod 2^32); ifid_instr <= imem_instr; ifid_pc_plus4 <= PC+4; ifid_valid <= 1; fetch_count +1, saturating at 32'hFFFF_FFFF.
REQ-026 flush=1 without stall: PC advances per REQ-025 but IF/ID loads bubble and fetch_count does not increment.
REQ-027 Fault check (combinational on pc_out): PC[1:0]!=0 or (PC>>2)>=IMEM_DEPTH, in RUN, no redirect, no stall -> next state FAULT, IF/ID bubble, PC held.
REQ-028 Halt check: imem_instr==HALT_INSTR, in RUN, no redirect, no stall, no fault -> next state HALTED, IF/ID bubble, PC held, fetch_count unchanged.
REQ-029 A HALT_INSTR or bad PC coinciding with redirect SHALL be ignored (wrong-path fetch).
REQ-030 HALTED and FAULT SHALL be exited only by rst; in them PC frozen, IF/ID bubble, all other inputs ignored.
REQ-031 Latency: instruction at PC appears on ifid_instr one edge after PC is presented on pc_out.

Reset
REQ-032 On rst=1 at an edge: pc_out=RESET_PC, ifid_instr=0, ifid_pc_plus4=0, ifid_valid=0, fetch_count=0, state RUN, halted=0, fault=0.
REQ-033 rst SHALL override every input in any state, including mid-stall and mid-redirect.

Structure
REQ-034 Shared package SHALL hold state encoding (RUN, HALTED, FAULT), NOP word 32'h0000_0000, default HALT_INSTR, and PC increment constant 4.
REQ-035 One sub-module if_id_register (registered instr, pc_plus4, valid with load/bubble/hold controls); PC logic and FSM stay in the top.

Verification
REQ-036 Reset, imem returns 32'h2008_0005 at PC 0 -> after 1 edge ifid_instr=32'h2008_0005, ifid_pc_plus4=4, pc_out=4, fetch_count=1.
REQ-037 stall=1 for 3 cycles at PC 8 -> pc_out stays 8, IF/ID and fetch_count unchanged; releasing resumes at 8.
REQ-038 branch_taken=1, target 32'h40, jump=1, target 32'h80, same cycle -> pc_out=32'h40, ifid_valid=0.
REQ-039 imem_instr=32'hFFFF_FFFF at PC 12 -> halted=1, pc_out stays 12, ifid_valid=0; ignores branch until rst.
REQ-040 jump to 32'h192 (misaligned) -> next cycle fault=1; jump to 400 (index 100) -> fault=1.
REQ-041 rst asserted while HALTED with stall=1 -> pc_out=0, halted=0, fetch_count=0 after one edge.
